// File: rtl/game_flow_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_flow_pkg
// Description : State encodings, round-result codes and default timing
//               constants shared by the match sequencer and its round timer.
// Revision    : 1.0 - initial release
// ============================================================================
package game_flow_pkg;

  typedef enum logic [2:0] {
    ST_MENU      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_FIGHT     = 3'd2,
    ST_ROUND_END = 3'd3,
    ST_MATCH_END = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_e;

  localparam int DEF_FRAMES_PER_SEC   = 60;
  localparam int DEF_ROUND_SECONDS    = 99;
  localparam int DEF_ROUND_END_FRAMES = 120;
  localparam int DEF_ROUNDS_TO_WIN    = 2;
  localparam int DEF_HEALTH_W         = 7;

  // Win counters stick at 3 rather than wrapping back to 0
  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'b11) ? v : v + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/round_timer_cnt.sv
`default_nettype none
// ============================================================================
// Module      : round_timer_cnt
// Description : Frame prescaler plus seconds down-counter for a fight round.
//               'expire' flags the frame tick that takes the count from 1 to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module round_timer_cnt
  import game_flow_pkg::*;
#(
  parameter int FRAMES_PER_SEC = DEF_FRAMES_PER_SEC,
  parameter int ROUND_SECONDS  = DEF_ROUND_SECONDS
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic       enable,
  input  logic       frame_tick,
  output logic [6:0] round_timer,
  output logic       expire
);

  localparam int             PW        = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [PW-1:0]  PRE_LAST  = PW'(FRAMES_PER_SEC - 1);
  localparam logic [PW-1:0]  PRE_ONE   = PW'(1);
  localparam logic [6:0]     SECS_INIT = 7'(ROUND_SECONDS);

  logic [PW-1:0] presc_q, presc_d;
  logic [6:0]    secs_q, secs_d;
  logic          wrap;

  // A second elapses on the tick where the prescaler sits at its last value
  assign wrap = enable && frame_tick && (presc_q == PRE_LAST);

  // Kept independent of 'load' so the parent can use it to pick its next state
  assign expire = wrap && (secs_q == 7'd1);

  // Next prescaler / seconds value: load wins over counting
  always_comb begin
    presc_d = presc_q;
    secs_d  = secs_q;
    if (load) begin
      presc_d = '0;
      secs_d  = SECS_INIT;
    end else if (enable && frame_tick) begin
      if (wrap) begin
        presc_d = '0;
        secs_d  = (secs_q != 7'd0) ? secs_q - 7'd1 : secs_q;
      end else begin
        presc_d = presc_q + PRE_ONE;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      secs_q  <= SECS_INIT;
    end else begin
      presc_q <= presc_d;
      secs_q  <= secs_d;
    end
  end

  assign round_timer = secs_q;

endmodule
`default_nettype wire

// File: rtl/game_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : game_flow_ctrl
// Description : Match sequencer: menu, countdown, fight, round end and match
//               end, with KO / time-out judging and best-of-N scoring.
// Revision    : 1.0 - initial release
// ============================================================================
module game_flow_ctrl
  import game_flow_pkg::*;
#(
  parameter int FRAMES_PER_SEC   = DEF_FRAMES_PER_SEC,
  parameter int ROUND_SECONDS    = DEF_ROUND_SECONDS,
  parameter int ROUND_END_FRAMES = DEF_ROUND_END_FRAMES,
  parameter int ROUNDS_TO_WIN    = DEF_ROUNDS_TO_WIN,
  parameter int HEALTH_W         = DEF_HEALTH_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                frame_tick,
  input  logic                start_btn,
  input  logic                trigger_gameplay_start,
  input  logic [HEALTH_W-1:0] p1_health,
  input  logic [HEALTH_W-1:0] p2_health,
  input  logic                p1_dead,
  input  logic                p2_dead,
  output logic [2:0]          state,
  output logic                count_can_start,
  output logic                gameplay_active,
  output logic                reset_round,
  output logic [6:0]          round_timer,
  output logic [1:0]          p1_wins,
  output logic [1:0]          p2_wins,
  output logic [1:0]          round_winner,
  output logic                match_over
);

  localparam logic [7:0] HOLD_LAST   = 8'(ROUND_END_FRAMES - 1);
  localparam logic [1:0] WINS_NEEDED = 2'(ROUNDS_TO_WIN);

  state_e     state_q, state_d;
  logic       start_prev_q;
  logic       start_rise;
  logic [1:0] p1_wins_q, p1_wins_d;
  logic [1:0] p2_wins_q, p2_wins_d;
  logic [1:0] round_winner_q, round_winner_d;
  logic [7:0] hold_q, hold_d;
  logic       count_can_start_q, count_can_start_d;
  logic       gameplay_active_q, gameplay_active_d;
  logic       reset_round_q, reset_round_d;
  logic       match_over_q, match_over_d;
  winner_e    result;
  logic       timer_load;
  logic       timer_en;
  logic       timer_expire;

  assign start_rise = start_btn && !start_prev_q;

  // The timer reloads whenever we are about to sit in MENU or COUNTDOWN, and
  // freezes on a KO so a KO racing expiry leaves the display at 1
  assign timer_load = (state_d == ST_MENU) || (state_d == ST_COUNTDOWN);
  assign timer_en   = (state_q == ST_FIGHT) && !p1_dead && !p2_dead;

  round_timer_cnt #(
    .FRAMES_PER_SEC (FRAMES_PER_SEC),
    .ROUND_SECONDS  (ROUND_SECONDS)
  ) u_round_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (timer_load),
    .enable      (timer_en),
    .frame_tick  (frame_tick),
    .round_timer (round_timer),
    .expire      (timer_expire)
  );

  // Next-state, scoring and hold-counter logic
  always_comb begin
    state_d        = state_q;
    p1_wins_d      = p1_wins_q;
    p2_wins_d      = p2_wins_q;
    round_winner_d = round_winner_q;
    hold_d         = hold_q;
    result         = WIN_NONE;
    case (state_q)
      ST_MENU: begin
        p1_wins_d      = 2'd0;
        p2_wins_d      = 2'd0;
        round_winner_d = WIN_NONE;
        if (start_rise) state_d = ST_COUNTDOWN;
      end
      ST_COUNTDOWN: begin
        if (trigger_gameplay_start) state_d = ST_FIGHT;
      end
      ST_FIGHT: begin
        if (p1_dead && p2_dead)             result = WIN_DRAW;
        else if (p1_dead)                   result = WIN_P2;
        else if (p2_dead)                   result = WIN_P1;
        else if (timer_expire) begin
          if (p1_health > p2_health)        result = WIN_P1;
          else if (p1_health < p2_health)   result = WIN_P2;
          else                              result = WIN_DRAW;
        end
        if (result != WIN_NONE) begin
          round_winner_d = result;
          if (result == WIN_P1) p1_wins_d = sat_inc(p1_wins_q);
          if (result == WIN_P2) p2_wins_d = sat_inc(p2_wins_q);
          hold_d  = 8'd0;
          state_d = ST_ROUND_END;
        end
      end
      ST_ROUND_END: begin
        if (frame_tick) begin
          if (hold_q == HOLD_LAST) begin
            if ((p1_wins_q >= WINS_NEEDED) || (p2_wins_q >= WINS_NEEDED))
              state_d = ST_MATCH_END;
            else
              state_d = ST_COUNTDOWN;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
      end
      ST_MATCH_END: begin
        // Clear scores on the way out so MENU shows a fresh match immediately
        if (start_rise) begin
          state_d        = ST_MENU;
          p1_wins_d      = 2'd0;
          p2_wins_d      = 2'd0;
          round_winner_d = WIN_NONE;
        end
      end
      default: begin
        state_d        = ST_MENU;
        p1_wins_d      = 2'd0;
        p2_wins_d      = 2'd0;
        round_winner_d = WIN_NONE;
      end
    endcase
  end

  // Status flags are decoded from the next state so they register with it
  always_comb begin
    count_can_start_d = (state_d == ST_COUNTDOWN);
    gameplay_active_d = (state_d == ST_FIGHT);
    match_over_d      = (state_d == ST_MATCH_END);
    reset_round_d     = (state_d == ST_COUNTDOWN) && (state_q != ST_COUNTDOWN);
  end

  // Sequencer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= ST_MENU;
      start_prev_q      <= 1'b0;
      p1_wins_q         <= 2'd0;
      p2_wins_q         <= 2'd0;
      round_winner_q    <= WIN_NONE;
      hold_q            <= 8'd0;
      count_can_start_q <= 1'b0;
      gameplay_active_q <= 1'b0;
      reset_round_q     <= 1'b0;
      match_over_q      <= 1'b0;
    end else begin
      state_q           <= state_d;
      start_prev_q      <= start_btn;
      p1_wins_q         <= p1_wins_d;
      p2_wins_q         <= p2_wins_d;
      round_winner_q    <= round_winner_d;
      hold_q            <= hold_d;
      count_can_start_q <= count_can_start_d;
      gameplay_active_q <= gameplay_active_d;
      reset_round_q     <= reset_round_d;
      match_over_q      <= match_over_d;
    end
  end

  assign state           = state_q;
  assign count_can_start = count_can_start_q;
  assign gameplay_active = gameplay_active_q;
  assign reset_round     = reset_round_q;
  assign p1_wins         = p1_wins_q;
  assign p2_wins         = p2_wins_q;
  assign round_winner    = round_winner_q;
  assign match_over      = match_over_q;

endmodule
`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_flow_ctrl
// Description : Directed bench for the match sequencer: reset, flow into the
//               fight, timer, KO races, round end, match end and restart.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_flow_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       frame_tick;
  logic       start_btn;
  logic       trigger_gameplay_start;
  logic [6:0] p1_health;
  logic [6:0] p2_health;
  logic       p1_dead;
  logic       p2_dead;
  logic [2:0] state;
  logic       count_can_start;
  logic       gameplay_active;
  logic       reset_round;
  logic [6:0] round_timer;
  logic [1:0] p1_wins;
  logic [1:0] p2_wins;
  logic [1:0] round_winner;
  logic       match_over;

  int n_checks = 0;
  int n_fail   = 0;

  game_flow_ctrl dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .frame_tick             (frame_tick),
    .start_btn              (start_btn),
    .trigger_gameplay_start (trigger_gameplay_start),
    .p1_health              (p1_health),
    .p2_health              (p2_health),
    .p1_dead                (p1_dead),
    .p2_dead                (p2_dead),
    .state                  (state),
    .count_can_start        (count_can_start),
    .gameplay_active        (gameplay_active),
    .reset_round            (reset_round),
    .round_timer            (round_timer),
    .p1_wins                (p1_wins),
    .p2_wins                (p2_wins),
    .round_winner           (round_winner),
    .match_over             (match_over)
  );

  always #5 clk = ~clk;

  // Packed output snapshot: {state, ccs, ga, rr, timer, p1w, p2w, winner, mo}
  function automatic logic [19:0] exp_out(input logic [2:0] st, input logic ccs,
                                          input logic ga, input logic rr,
                                          input logic [6:0] tmr, input logic [1:0] p1w,
                                          input logic [1:0] p2w, input logic [1:0] rw,
                                          input logic mo);
    return {st, ccs, ga, rr, tmr, p1w, p2w, rw, mo};
  endfunction

  function automatic logic [19:0] act_out();
    return {state, count_can_start, gameplay_active, reset_round, round_timer,
            p1_wins, p2_wins, round_winner, match_over};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame: tick high for a clk, then low for a clk
  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  // 120 ticks in ROUND_END: state must hold 3 through tick 119, then leave
  task automatic round_end_hold(input string name, input logic [19:0] exp_after);
    for (int i = 1; i < 120; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
      check({name, " hold"}, {29'd0, state}, 32'd3);
    end
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check({name, " exit"}, {12'd0, act_out()}, {12'd0, exp_after});
  endtask

  typedef struct {
    string       name;
    logic        start;
    logic        trig;
    logic        tick;
    logic        p1d;
    logic        p2d;
    logic [19:0] exp;
  } vec_t;

  vec_t ph1[5];
  vec_t ph2[2];

  task automatic run_vec(input vec_t v);
    start_btn              = v.start;
    trigger_gameplay_start = v.trig;
    frame_tick             = v.tick;
    p1_dead                = v.p1d;
    p2_dead                = v.p2d;
    step();
    check(v.name, {12'd0, act_out()}, {12'd0, v.exp});
  endtask

  initial begin
    // Flow from MENU into FIGHT
    ph1[0] = '{"menu idle",   0, 0, 0, 0, 0, exp_out(3'd0, 0, 0, 0, 7'd99, 2'd0, 2'd0, 2'b00, 0)};
    ph1[1] = '{"start press", 1, 0, 0, 0, 0, exp_out(3'd1, 1, 0, 1, 7'd99, 2'd0, 2'd0, 2'b00, 0)};
    ph1[2] = '{"countdown",   0, 0, 0, 0, 0, exp_out(3'd1, 1, 0, 0, 7'd99, 2'd0, 2'd0, 2'b00, 0)};
    ph1[3] = '{"enter fight", 0, 1, 0, 0, 0, exp_out(3'd2, 0, 1, 0, 7'd99, 2'd0, 2'd0, 2'b00, 0)};
    ph1[4] = '{"first tick",  0, 0, 1, 0, 0, exp_out(3'd2, 0, 1, 0, 7'd99, 2'd0, 2'd0, 2'b00, 0)};
    // Double KO from COUNTDOWN with p1_wins=1 already banked, winner still 01
    ph2[0] = '{"fight 2",     0, 1, 0, 0, 0, exp_out(3'd2, 0, 1, 0, 7'd99, 2'd1, 2'd0, 2'b01, 0)};
    ph2[1] = '{"double KO",   0, 0, 0, 1, 1, exp_out(3'd3, 0, 0, 0, 7'd99, 2'd1, 2'd0, 2'b11, 0)};

    reset_n                = 1'b0;
    frame_tick             = 1'b0;
    start_btn              = 1'b0;
    trigger_gameplay_start = 1'b0;
    p1_health              = 7'd50;
    p2_health              = 7'd30;
    p1_dead                = 1'b0;
    p2_dead                = 1'b0;
    #12;
    check("reset state", {12'd0, act_out()},
          {12'd0, exp_out(3'd0, 0, 0, 0, 7'd99, 2'd0, 2'd0, 2'b00, 0)});
    @(negedge clk);
    reset_n = 1'b1;

    foreach (ph1[i]) run_vec(ph1[i]);
    frame_tick = 1'b0;

    // 59 more ticks completes the first second
    do_ticks(59);
    check("timer 98", {25'd0, round_timer}, 32'd98);
    // Up to tick 5939: one frame short of time-out
    do_ticks(99 * 60 - 61);
    check("timer at 1", {25'd0, round_timer}, 32'd1);
    check("still fight", {29'd0, state}, 32'd2);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("time-out", {12'd0, act_out()},
          {12'd0, exp_out(3'd3, 0, 0, 0, 7'd0, 2'd1, 2'd0, 2'b01, 0)});
    step();

    round_end_hold("re1", exp_out(3'd1, 1, 0, 1, 7'd99, 2'd1, 2'd0, 2'b01, 0));
    step();
    check("reset_round single", {31'd0, reset_round}, 32'd0);

    foreach (ph2[i]) run_vec(ph2[i]);
    p1_dead = 1'b0;
    p2_dead = 1'b0;
    trigger_gameplay_start = 1'b0;
    step();
    round_end_hold("re2", exp_out(3'd1, 1, 0, 1, 7'd99, 2'd1, 2'd0, 2'b11, 0));

    // KO racing timer expiry: KO wins, timer stays at 1
    trigger_gameplay_start = 1'b1;
    step();
    trigger_gameplay_start = 1'b0;
    do_ticks(99 * 60 - 1);
    frame_tick = 1'b1;
    p2_dead    = 1'b1;
    step();
    frame_tick = 1'b0;
    p2_dead    = 1'b0;
    check("KO vs expiry", {12'd0, act_out()},
          {12'd0, exp_out(3'd3, 0, 0, 0, 7'd1, 2'd2, 2'd0, 2'b01, 0)});
    step();
    round_end_hold("re3", exp_out(3'd4, 0, 0, 0, 7'd1, 2'd2, 2'd0, 2'b01, 1));

    // Held start gives exactly one exit to MENU
    start_btn = 1'b1;
    step();
    check("to menu", {12'd0, act_out()},
          {12'd0, exp_out(3'd0, 0, 0, 0, 7'd99, 2'd0, 2'd0, 2'b00, 0)});
    step();
    step();
    check("held start stays menu", {29'd0, state}, 32'd0);
    start_btn = 1'b0;
    step();
    start_btn = 1'b1;
    step();
    check("new match", {12'd0, act_out()},
          {12'd0, exp_out(3'd1, 1, 0, 1, 7'd99, 2'd0, 2'd0, 2'b00, 0)});
    start_btn = 1'b0;

    // Bank a P1 KO win, then run the next round down to 42 for the reset test
    trigger_gameplay_start = 1'b1;
    step();
    trigger_gameplay_start = 1'b0;
    p2_dead = 1'b1;
    step();
    p2_dead = 1'b0;
    check("p1 KO win", {30'd0, p1_wins}, 32'd1);
    step();
    round_end_hold("re4", exp_out(3'd1, 1, 0, 1, 7'd99, 2'd1, 2'd0, 2'b01, 0));
    trigger_gameplay_start = 1'b1;
    step();
    trigger_gameplay_start = 1'b0;
    do_ticks(57 * 60);
    check("timer 42", {25'd0, round_timer}, 32'd42);
    check("fight before reset", {29'd0, state}, 32'd2);

    // Asynchronous reset mid-cycle, checked before any clk edge
    #1;
    reset_n = 1'b0;
    #1;
    check("async reset", {12'd0, act_out()},
          {12'd0, exp_out(3'd0, 0, 0, 0, 7'd99, 2'd0, 2'd0, 2'b00, 0)});
    @(negedge clk);
    reset_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
